// File: rtl/alu_sequencer.sv
// Sequences one request at a time through an external combinational ALU: IDLE -> EXEC -> DONE.
// Optional macro ALU_SEQ_DIVZERO_CHECK_EN short-circuits DIV by zero with an error response.
module alu_sequencer #(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 8
) (
  input  logic        clock,
  input  logic        clear_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [3:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [63:0] alu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_lo,
  output logic [31:0] rsp_hi,
  output logic        rsp_err,
  output logic        busy
);

  localparam logic [3:0] OpMul    = 4'd11;
  localparam logic [3:0] OpDiv    = 4'd12;
  localparam logic [3:0] MulLoad  = 4'(MUL_CYCLES - 1);
  localparam logic [3:0] DivLoad  = 4'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  alu_op_q, alu_op_d;
  logic [31:0] alu_a_q, alu_a_d;
  logic [31:0] alu_b_q, alu_b_d;
  logic [31:0] rsp_lo_q, rsp_lo_d;
  logic [31:0] rsp_hi_q, rsp_hi_d;
  logic        rsp_err_q, rsp_err_d;
  logic        div_zero;

`ifdef ALU_SEQ_DIVZERO_CHECK_EN
  assign div_zero = (alu_op_q == OpDiv) && (alu_b_q == 32'd0);
`else
  assign div_zero = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    alu_op_d  = alu_op_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    rsp_lo_d  = rsp_lo_q;
    rsp_hi_d  = rsp_hi_q;
    rsp_err_d = rsp_err_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          alu_op_d = req_op;
          alu_a_d  = req_a;
          alu_b_d  = req_b;
          state_d  = StExec;
          if (req_op == OpMul) begin
            cnt_d = MulLoad;
          end else if (req_op == OpDiv) begin
            cnt_d = DivLoad;
`ifdef ALU_SEQ_DIVZERO_CHECK_EN
            if (req_b == 32'd0) cnt_d = 4'd0;
`endif
          end else begin
            cnt_d = 4'd0;
          end
        end
      end
      StExec: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = StDone;
          if (alu_op_q > OpDiv) begin
            rsp_lo_d  = 32'd0;
            rsp_hi_d  = 32'd0;
            rsp_err_d = 1'b1;
          end else if (div_zero) begin
            rsp_lo_d  = 32'hFFFF_FFFF;
            rsp_hi_d  = alu_a_q;
            rsp_err_d = 1'b1;
          end else begin
            rsp_lo_d  = alu_result[31:0];
            rsp_hi_d  = alu_result[63:32];
            rsp_err_d = 1'b0;
          end
        end
      end
      StDone: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      alu_op_q  <= 4'd0;
      alu_a_q   <= 32'd0;
      alu_b_q   <= 32'd0;
      rsp_lo_q  <= 32'd0;
      rsp_hi_q  <= 32'd0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      alu_op_q  <= alu_op_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      rsp_lo_q  <= rsp_lo_d;
      rsp_hi_q  <= rsp_hi_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign req_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign alu_op    = alu_op_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign rsp_lo    = rsp_lo_q;
  assign rsp_hi    = rsp_hi_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter MUL_CYCLES, default 4, cycles op 11 (MUL) occupies the ALU before capture; legal range 1..15.
REQ-002 Parameter DIV_CYCLES, default 8, cycles op 12 (DIV) occupies the ALU before capture; legal range 1..15.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 clear_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid / req_ready  input / output  1 / 1  request handshake; transfer when both high on a rising edge.
REQ-006 req_op / req_a / req_b  input  4 / 32 / 32  op code (0 OR, 1 AND, 2 NOT, 3 ADD, 4 SUB, 5 SHR, 6 SHRA, 7 SHL, 8 ROR, 9 ROL, 10 NEG, 11 MUL, 12 DIV) and operands.
REQ-007 alu_op / alu_a / alu_b  output  4 / 32 / 32  registered drive to the combinational ALU.
REQ-008 alu_result  input  64  ALU result; DIV returns {remainder, quotient}.
REQ-009 rsp_valid / rsp_ready  output / input  1 / 1  response handshake.
REQ-010 rsp_lo / rsp_hi / rsp_err  output  32 / 32 / 1  captured result low/high halves and error flag.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 States IDLE, EXEC, DONE; req_ready SHALL equal (state == IDLE).
REQ-013 IDLE: on request transfer, latch req_op/req_a/req_b into alu_op/alu_a/alu_b, load cycle counter, go to EXEC.
REQ-014 Counter load: MUL_CYCLES-1 for op 11, DIV_CYCLES-1 for op 12, 0 for all other ops.
REQ-015 EXEC: counter nonzero -> decrement, stay; counter zero -> capture alu_result[31:0] into rsp_lo, alu_result[63:32] into rsp_hi, go to DONE.
REQ-016 Latency: accept at edge N; single-cycle ops rsp_valid high after edge N+1; MUL after edge N+MUL_CYCLES; DIV after edge N+DIV_CYCLES.
REQ-017 alu_op/alu_a/alu_b SHALL remain stable from accept until the DONE-to-IDLE transition.
REQ-018 rsp_valid SHALL equal (state == DONE); rsp_lo/rsp_hi/rsp_err held stable while rsp_valid and not rsp_ready.
REQ-019 DONE: rsp_ready high -> IDLE; no new request accepted in the same edge (req_ready low in DONE).
REQ-020 Illegal op 13..15: counter 0, rsp_lo = rsp_hi = 0, rsp_err = 1.
REQ-021 Legal ops SHALL return rsp_err = 0 except per REQ-026.
REQ-022 req_valid while not IDLE SHALL be ignored without side effects.

Reset
REQ-023 clear_n low SHALL immediately force state IDLE, counter 0, alu_op/alu_a/alu_b 0, rsp_lo/rsp_hi 0, rsp_err 0; hence rsp_valid 0, busy 0, req_ready 1.
REQ-024 Reset during EXEC or DONE SHALL discard the in-flight operation; no response after release.
REQ-025 First request accepted on the first rising edge after clear_n deasserts if req_valid is high.

Configuration
REQ-026 Macro ALU_SEQ_DIVZERO_CHECK_EN defined: op 12 with req_b == 0 SHALL load counter 0, capture rsp_lo = 32'hFFFFFFFF, rsp_hi = req_a, rsp_err = 1, ignoring alu_result.
REQ-027 Macro undefined: op 12 with req_b == 0 follows normal DIV_CYCLES path, captures alu_result, rsp_err = 0.

Verification
REQ-028 ADD a=5, b=7, rsp_ready=1 -> rsp_valid one cycle after accept, rsp_lo=12, rsp_hi=0, rsp_err=0.
REQ-029 MUL a=32'h10000, b=32'h10000, default params -> rsp_valid 4 cycles after accept, rsp_hi=1, rsp_lo=0, alu inputs stable throughout.
REQ-030 DIV a=17, b=5 -> rsp_valid 8 cycles after accept, rsp_lo=3, rsp_hi=2; rsp_ready held low 3 cycles -> outputs stable, req_ready low until handshake.
REQ-031 DIV a=9, b=0 with macro -> rsp_valid 1 cycle after accept, rsp_lo=32'hFFFFFFFF, rsp_hi=9, rsp_err=1; without macro -> 8-cycle latency, rsp_err=0.
REQ-032 op=14 -> rsp_lo=0, rsp_hi=0, rsp_err=1 after 1 cycle; second req_valid during EXEC ignored.
REQ-033 clear_n pulsed low mid-MUL -> all outputs zero asynchronously, no rsp_valid afterward, next ADD completes normally.
